// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU front end (input staging, array edge).
package tpu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DRAIN_CYCLES   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stager_state_t;

endpackage

// File: rtl/input_stager_lane.sv
// One row of the stager: delays the pop strobe, captures the returned word
// and flags a pop that came back without valid data.
module input_stager_lane
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop_i,
  input  logic                  acc_valid_i,
  input  logic [DATA_WIDTH-1:0] acc_data_i,
  output logic                  sys_valid_o,
  output logic [DATA_WIDTH-1:0] sys_data_o,
  output logic                  underflow_c_o
);

  logic                  pop_d1_q;
  logic                  capture_c;
  logic                  sys_valid_q;
  logic [DATA_WIDTH-1:0] sys_data_q;
  logic [DATA_WIDTH-1:0] sys_data_d;

  // Word is expected exactly one cycle after the pop; anything else is ignored.
  assign capture_c  = pop_d1_q & acc_valid_i;
  assign sys_data_d = capture_c ? acc_data_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_d1_q    <= 1'b0;
      sys_valid_q <= 1'b0;
      sys_data_q  <= '0;
    end else begin
      pop_d1_q    <= pop_i;
      sys_valid_q <= capture_c;
      sys_data_q  <= sys_data_d;
    end
  end

  assign sys_valid_o   = sys_valid_q;
  assign sys_data_o    = sys_data_q;
  assign underflow_c_o = pop_d1_q & ~acc_valid_i;

endmodule

// File: rtl/input_stager.sv
// Skewed dequeue sequencer feeding the west edge of the systolic array.
// Optional stall input enabled by defining INPUT_STAGER_STALL_EN.
module input_stager
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS       = 2,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           len,
`ifdef INPUT_STAGER_STALL_EN
  input  logic                           stall,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           underflow,
  output logic [ROWS-1:0]                pop_out,
  input  logic [ROWS-1:0]                acc_valid_in,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0] acc_data_in,
  output logic [ROWS-1:0]                sys_valid_out,
  output logic [ROWS-1:0][DATA_WIDTH-1:0] sys_data_out
);

  localparam int unsigned CYC_WIDTH = LEN_WIDTH + $clog2(ROWS) + 1;

  stager_state_t          state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [CYC_WIDTH-1:0]   cyc_q, cyc_d;
  logic [CYC_WIDTH-1:0]   last_cyc_c;
  logic [ROWS-1:0]        pop_q, pop_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   underflow_q, underflow_d;
  logic [ROWS-1:0]        lane_uf_c;
  logic                   stall_run_c;

  // Row r pops while the wavefront index sits in [r, r+n).
  function automatic logic [ROWS-1:0] pop_pattern(input logic [CYC_WIDTH-1:0] cyc,
                                                  input logic [LEN_WIDTH-1:0] n);
    logic [ROWS-1:0] pat;
    pat = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      pat[r] = (cyc >= CYC_WIDTH'(r)) && (cyc < CYC_WIDTH'(r) + CYC_WIDTH'(n));
    end
    return pat;
  endfunction

`ifdef INPUT_STAGER_STALL_EN
  assign stall_run_c = stall && (state_q == RUN);
`else
  assign stall_run_c = 1'b0;
`endif

  assign last_cyc_c = CYC_WIDTH'(len_q) + CYC_WIDTH'(ROWS) - CYC_WIDTH'(2);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cyc_d       = cyc_q;
    pop_d       = pop_q;
    done_d      = 1'b0;
    underflow_d = underflow_q | (|lane_uf_c);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = RUN;
            len_d       = len;
            cyc_d       = '0;
            pop_d       = pop_pattern('0, len);
            underflow_d = |lane_uf_c;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A stalled cycle holds the counter and pop pattern for all rows at once.
        if (!stall_run_c) begin
          if (cyc_q == last_cyc_c) begin
            state_d = DRAIN;
            cyc_d   = '0;
            pop_d   = '0;
          end else begin
            cyc_d = cyc_q + CYC_WIDTH'(1);
            pop_d = pop_pattern(cyc_q + CYC_WIDTH'(1), len_q);
          end
        end
      end
      DRAIN: begin
        if (cyc_q == CYC_WIDTH'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pop_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cyc_q       <= '0;
      pop_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cyc_q       <= cyc_d;
      pop_q       <= pop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  assign pop_out   = pop_q & ~{ROWS{stall_run_c}};
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = underflow_q;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
    input_stager_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .pop_i        (pop_out[gi]),
      .acc_valid_i  (acc_valid_in[gi]),
      .acc_data_i   (acc_data_in[gi]),
      .sys_valid_o  (sys_valid_out[gi]),
      .sys_data_o   (sys_data_out[gi]),
      .underflow_c_o(lane_uf_c[gi])
    );
  end

endmodule

// File: tb/tb_input_stager.sv
// Self-checking bench for input_stager: directed table, hand sequences and
// randomized runs against a wavefront-level reference model.
module tb_input_stager;

  localparam int unsigned ROWS = 2;
  localparam int unsigned DW   = 16;
  localparam int unsigned LW   = 8;
  localparam int MAXW = 16;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [LW-1:0] len;
`ifdef INPUT_STAGER_STALL_EN
  logic stall;
`endif
  logic busy, done, underflow;
  logic [ROWS-1:0] pop_out;
  logic [ROWS-1:0] acc_valid_in;
  logic [ROWS-1:0][DW-1:0] acc_data_in;
  logic [ROWS-1:0] sys_valid_out;
  logic [ROWS-1:0][DW-1:0] sys_data_out;

  always #5 clk = ~clk;

  input_stager #(.ROWS(ROWS), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
`ifdef INPUT_STAGER_STALL_EN
    .stall        (stall),
`endif
    .busy         (busy),
    .done         (done),
    .underflow    (underflow),
    .pop_out      (pop_out),
    .acc_valid_in (acc_valid_in),
    .acc_data_in  (acc_data_in),
    .sys_valid_out(sys_valid_out),
    .sys_data_out (sys_data_out)
  );

  // Accumulator contents and which words each accumulator fails to deliver.
  logic [DW-1:0] words [ROWS][MAXW];
  bit            wh    [ROWS][MAXW];
  int            rd    [ROWS];

  // Expected waveforms, indexed by cycles after the start edge.
  logic [ROWS-1:0] e_pop  [MAXC];
  logic [ROWS-1:0] e_sv   [MAXC];
  logic [DW-1:0]   e_sd   [MAXC][ROWS];
  logic            e_busy [MAXC];
  logic            e_done [MAXC];
  logic            e_uf   [MAXC];
  int              e_done_k;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int           len;
    bit [MAXC-1:0] st;
    bit [15:0]    wh0;
    bit [15:0]    wh1;
    int           xs_k;
    int           xs_len;
    bit           chain;
    int           exp_done;
    bit           exp_uf;
  } vec_t;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
  endtask

  // One clock; the accumulator answers a pop seen in the ending cycle.
  task automatic tick();
    logic [ROWS-1:0] pend;
    pend = pop_out;
    @(posedge clk);
    #1;
    for (int r = 0; r < ROWS; r++) begin
      if (pend[r]) begin
        if (rd[r] < MAXW && !wh[r][rd[r]]) begin
          acc_valid_in[r] = 1'b1;
          acc_data_in[r]  = words[r][rd[r]];
        end else begin
          acc_valid_in[r] = 1'b0;
          acc_data_in[r]  = DW'($urandom);
        end
        rd[r]++;
      end else begin
        acc_valid_in[r] = 1'($urandom_range(0, 1));
        acc_data_in[r]  = DW'($urandom);
      end
    end
  endtask

  task automatic load_words(input bit directed, input bit [15:0] wh0, input bit [15:0] wh1);
    for (int j = 0; j < MAXW; j++) begin
      words[0][j] = directed ? DW'(10 * (j + 1)) : DW'($urandom);
      words[1][j] = directed ? DW'(5 + j) : DW'($urandom);
      wh[0][j]    = wh0[j];
      wh[1][j]    = wh1[j];
    end
  endtask

  // Wavefront n advances once per unstalled cycle; row r pops while r <= n < r+L.
  task automatic build_model(input int L, input bit [MAXC-1:0] st);
    int n, k, cnt;
    for (int c = 0; c < MAXC; c++) begin
      e_pop[c] = '0; e_sv[c] = '0; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_uf[c] = 1'b0;
      for (int r = 0; r < ROWS; r++) e_sd[c][r] = '0;
    end
    n = 0;
    k = 1;
    while (n < L + int'(ROWS) - 1 && k < MAXC - 4) begin
      e_busy[k] = 1'b1;
      if (!st[k]) begin
        for (int r = 0; r < ROWS; r++) if (n >= r && n < r + L) e_pop[k][r] = 1'b1;
        n++;
      end
      k++;
    end
    e_busy[k] = 1'b1;
    e_busy[k+1] = 1'b1;
    e_done[k+2] = 1'b1;
    e_done_k = k + 2;
    for (int r = 0; r < ROWS; r++) begin
      cnt = 0;
      for (int c = 1; c <= e_done_k; c++) begin
        if (e_pop[c][r]) begin
          if (!wh[r][cnt]) begin
            e_sv[c+2][r] = 1'b1;
            e_sd[c+2][r] = words[r][cnt];
          end else begin
            for (int c2 = c + 2; c2 < MAXC; c2++) e_uf[c2] = 1'b1;
          end
          cnt++;
        end
      end
    end
  endtask

  task automatic check_cycle(input int k);
    chk("busy", k, 64'(busy), 64'(e_busy[k]));
    chk("done", k, 64'(done), 64'(e_done[k]));
    chk("underflow", k, 64'(underflow), 64'(e_uf[k]));
    chk("pop_out", k, 64'(pop_out), 64'(e_pop[k]));
    chk("sys_valid_out", k, 64'(sys_valid_out), 64'(e_sv[k]));
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("sys_data_out[%0d]", r), k, 64'(sys_data_out[r]), 64'(e_sd[k][r]));
  endtask

  // Starts in the current cycle and returns in the cycle done is expected.
  task automatic run_case(input int L, input bit [MAXC-1:0] st, input int xs_k, input int xs_len,
                          output int done_k, output logic uf_end);
    build_model(L, st);
    for (int r = 0; r < ROWS; r++) rd[r] = 0;
    start = 1'b1;
    len   = LW'(L);
    tick();
    done_k = -1;
    uf_end = 1'bx;
    for (int k = 1; k <= e_done_k; k++) begin
      start = (k == xs_k);
      len   = (k == xs_k) ? LW'(xs_len) : LW'($urandom);
`ifdef INPUT_STAGER_STALL_EN
      stall = st[k];
`endif
      #1;
      check_cycle(k);
      if (done === 1'b1 && done_k < 0) done_k = k;
      uf_end = underflow;
      if (k < e_done_k) tick();
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input int n, input logic uf_exp);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      tick();
      #1;
      chk("idle busy", i, 64'(busy), 64'd0);
      chk("idle done", i, 64'(done), 64'd0);
      chk("idle pop_out", i, 64'(pop_out), 64'd0);
      chk("idle sys_valid_out", i, 64'(sys_valid_out), 64'd0);
      chk("idle underflow", i, 64'(underflow), 64'(uf_exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    int dk;
    logic ue;
    int L, xs_k;
    bit [MAXC-1:0] st;

    rst = 1'b1; start = 1'b0; len = '0; acc_valid_in = '0; acc_data_in = '0;
`ifdef INPUT_STAGER_STALL_EN
    stall = 1'b0;
`endif
    for (int r = 0; r < ROWS; r++) rd[r] = 0;
    load_words(1'b1, 16'h0, 16'h0);
    tick();
    #1;
    chk("reset busy", 0, 64'(busy), 64'd0);
    chk("reset done", 0, 64'(done), 64'd0);
    chk("reset underflow", 0, 64'(underflow), 64'd0);
    chk("reset pop_out", 0, 64'(pop_out), 64'd0);
    chk("reset sys_valid_out", 0, 64'(sys_valid_out), 64'd0);
    chk("reset sys_data_out", 0, 64'(sys_data_out), 64'd0);
    rst = 1'b0;
    tick();

    // len=0: done next cycle, nothing else moves.
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    #1;
    chk("len0 done", 1, 64'(done), 64'd1);
    chk("len0 busy", 1, 64'(busy), 64'd0);
    chk("len0 pop_out", 1, 64'(pop_out), 64'd0);
    idle_check(3, 1'b0);

    vecs.push_back('{3, '0, 16'h0000, 16'h0000, 0, 0, 1'b0, 7, 1'b0});
    vecs.push_back('{3, '0, 16'h0000, 16'h0000, 2, 9, 1'b0, 7, 1'b0});
    vecs.push_back('{3, '0, 16'h0000, 16'h0002, 0, 0, 1'b1, 7, 1'b1});
    vecs.push_back('{1, '0, 16'h0000, 16'h0000, 0, 0, 1'b0, 5, 1'b0});
    vecs.push_back('{5, '0, 16'h0001, 16'h0010, 3, 1, 1'b0, 9, 1'b1});
`ifdef INPUT_STAGER_STALL_EN
    vecs.push_back('{3, 64'h000c, 16'h0000, 16'h0000, 0, 0, 1'b0, 9, 1'b0});
    vecs.push_back('{2, 64'h0070, 16'h0000, 16'h0000, 0, 0, 1'b0, 6, 1'b0});
`endif
    foreach (vecs[i]) begin
      v = vecs[i];
      load_words(1'b1, v.wh0, v.wh1);
      run_case(v.len, v.st, v.xs_k, v.xs_len, dk, ue);
      chk($sformatf("vec%0d done cycle", i), dk, 64'(dk), 64'(v.exp_done));
      chk($sformatf("vec%0d final underflow", i), dk, 64'(ue), 64'(v.exp_uf));
      if (!v.chain) idle_check(2, v.exp_uf);
    end

    // Reset in the middle of a len=4 run with row0's first word missing.
    load_words(1'b1, 16'h0001, 16'h0000);
    build_model(4, '0);
    for (int r = 0; r < ROWS; r++) rd[r] = 0;
    start = 1'b1; len = LW'(4);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check_cycle(k);
      if (k < 3) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst busy", 4, 64'(busy), 64'd0);
    chk("rst done", 4, 64'(done), 64'd0);
    chk("rst underflow", 4, 64'(underflow), 64'd0);
    chk("rst pop_out", 4, 64'(pop_out), 64'd0);
    chk("rst sys_valid_out", 4, 64'(sys_valid_out), 64'd0);
    chk("rst sys_data_out", 4, 64'(sys_data_out), 64'd0);
    idle_check(8, 1'b0);
    load_words(1'b1, 16'h0, 16'h0);
    run_case(3, '0, 0, 0, dk, ue);
    chk("post-reset done cycle", dk, 64'(dk), 64'd7);
    idle_check(1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      L = $urandom_range(1, 12);
      load_words(1'b0, 16'($urandom), 16'($urandom));
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < MAXW; j++) wh[r][j] = ($urandom_range(0, 3) == 0);
      st = '0;
`ifdef INPUT_STAGER_STALL_EN
      for (int c = 1; c < 40; c++) st[c] = ($urandom_range(0, 3) == 0);
`endif
      xs_k = ($urandom_range(0, 1) == 1) ? $urandom_range(2, L + int'(ROWS)) : 0;
      run_case(L, st, xs_k, $urandom_range(0, 200), dk, ue);
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3), e_uf[e_done_k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
